// File: rtl/xc_uart_pkg.sv
// Shared types for the XC board command receiver: FSM state encoding,
// the byte type carried through the FIFO, and the bit-period helper.
// Optional feature macro used by the receiver: XC_UART_RX_PARITY_EN.
package xc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } xc_state_e;

    typedef logic [7:0] xc_byte_t;

    // Width of the bit-timing down-counter.
    localparam int unsigned XC_CNT_W = 16;

    // Number of sysclk cycles in one serial bit, truncated.
    function automatic int unsigned xc_clks_per_bit(input int unsigned clk_frequency,
                                                    input int unsigned baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/xc_uart_rx_if.sv
// Byte-stream handshake between the UART receiver and the control logic.
// The receiver owns the master side; the consumer owns the slave side.
interface xc_uart_rx_if;
    import xc_uart_pkg::*;

    xc_byte_t data_out;
    logic     data_valid;
    logic     data_ready;
    logic     framing_err;
    logic     overrun;
    logic     busy;

    modport master (
        output data_out,
        output data_valid,
        output framing_err,
        output overrun,
        output busy,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  overrun,
        input  busy,
        output data_ready
    );

endinterface

// File: rtl/xc_byte_fifo.sv
// Small synchronous byte FIFO. The head byte is held in a register so the
// output is glitch-free and a byte pushed into an empty FIFO only becomes
// visible on the following cycle (no fall-through). A push while full is
// accepted only when a pop happens in the same cycle.
module xc_byte_fifo
    import xc_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     sysclk,
    input  logic     reset_n,
    input  logic     i_push,
    input  xc_byte_t i_wr_data,
    input  logic     i_pop,
    output xc_byte_t o_rd_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_wr_ptr_next;
    logic [AW:0] w_rd_ptr_next;
    xc_byte_t    r_mem [DEPTH];
    xc_byte_t    r_head;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty       = (r_wr_ptr == r_rd_ptr);
    assign o_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop      = i_pop && !o_empty;
    assign w_do_push     = i_push && (!o_full || w_do_pop);
    assign w_wr_ptr_next = w_do_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    assign w_rd_ptr_next = w_do_pop  ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    assign o_rd_data     = r_head;

    // Storage array write port; contents need no reset.
    always_ff @(posedge sysclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers, flushed by reset.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Registered head: the new head is either the byte being written into
    // the slot that becomes the head, or a byte already in the array.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_head <= '0;
        end else if (w_do_push && (w_rd_ptr_next == r_wr_ptr)) begin
            r_head <= i_wr_data;
        end else if (w_wr_ptr_next != w_rd_ptr_next) begin
            r_head <= r_mem[w_rd_ptr_next[AW-1:0]];
        end
    end

endmodule

// File: rtl/xc_uart_rx.sv
// XC correlator board command receiver: samples the RX header pin on
// sysclk, decodes 8N1 frames (8E1 when XC_UART_RX_PARITY_EN is defined),
// buffers bytes in a small FIFO and reports framing/overrun as one-cycle
// pulses. A held-low line parks in BREAK so it never yields bytes.
module xc_uart_rx
    import xc_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 10000000,
    parameter int unsigned BAUD_RATE     = 57600,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         rx,
    xc_uart_rx_if.master rx_bus
);

    localparam int unsigned CLKS_PER_BIT = xc_clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    // The counter expires on the cycle it reads zero, so a full bit period
    // reloads with CLKS_PER_BIT-1. The start load of HALF_BIT places the
    // start-bit check one cycle past mid-bit, which keeps START-entry to
    // push at exactly HALF_BIT + 9 bit periods.
    localparam logic [XC_CNT_W-1:0] LOAD_HALF = XC_CNT_W'(HALF_BIT);
    localparam logic [XC_CNT_W-1:0] LOAD_BIT  = XC_CNT_W'(CLKS_PER_BIT - 1);

    logic                r_rx_meta;
    logic                r_rx_s;
    xc_state_e           r_state;
    xc_state_e           w_state_next;
    logic [XC_CNT_W-1:0] r_cnt;
    logic [XC_CNT_W-1:0] w_cnt_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_next;
    xc_byte_t            r_shift;
    xc_byte_t            w_shift_next;
    logic                r_framing_err;
    logic                r_overrun;
    logic                w_expired;
    logic                w_push;
    logic                w_frame_bad;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    xc_byte_t            w_fifo_head;
`ifdef XC_UART_RX_PARITY_EN
    logic                r_parity_err;
    logic                w_parity_err_next;
`endif

    assign w_expired = (r_cnt == '0);
    assign w_pop     = !w_fifo_empty && rx_bus.data_ready;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

`ifdef XC_UART_RX_PARITY_EN
    // Parity verdict captured at the parity sample, used at the stop sample.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_err_next;
        end
    end
`endif

    // Next-state logic: sample each bit when the timer expires.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_expired ? r_cnt : r_cnt - XC_CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_push         = 1'b0;
        w_frame_bad    = 1'b0;
`ifdef XC_UART_RX_PARITY_EN
        w_parity_err_next = r_parity_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = LOAD_HALF;
                end
            end
            ST_START: begin
                if (w_expired) begin
                    if (r_rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next   = ST_DATA;
                        w_cnt_next     = LOAD_BIT;
                        w_bit_idx_next = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (w_expired) begin
                    w_shift_next   = {r_rx_s, r_shift[7:1]};
                    w_cnt_next     = LOAD_BIT;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef XC_UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef XC_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_expired) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    w_parity_err_next = ^{r_shift, r_rx_s};
                    w_state_next      = ST_STOP;
                    w_cnt_next        = LOAD_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (w_expired) begin
                    if (!r_rx_s) begin
                        w_frame_bad  = 1'b1;
                        w_state_next = ST_BREAK;
                    end else begin
`ifdef XC_UART_RX_PARITY_EN
                        w_frame_bad = r_parity_err;
                        w_push      = !r_parity_err;
`else
                        w_push      = 1'b1;
`endif
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= w_frame_bad;
            r_overrun     <= w_push && w_fifo_full && !w_pop;
        end
    end

    xc_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_wr_data (r_shift),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign rx_bus.data_out    = w_fifo_head;
    assign rx_bus.data_valid  = !w_fifo_empty;
    assign rx_bus.framing_err = r_framing_err;
    assign rx_bus.overrun     = r_overrun;
    assign rx_bus.busy        = (r_state != ST_IDLE);

endmodule

// File: doc/xc_uart_rx.md
# xc_uart_rx

Board-level command receiver between the RX header pin and the `main` block of the XC correlator boards. It samples the asynchronous RX line on `sysclk` and decodes 8N1 frames at `BAUD_RATE`. Received bytes are buffered in a small FIFO and presented to the control logic through a valid/ready handshake. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `CLK_FREQUENCY`, default 10000000: `sysclk` frequency in Hz.
- `BAUD_RATE`, default 57600: serial bit rate.
- `FIFO_DEPTH`, default 4: byte buffer depth. Must be a power of two, at least 2.
- `sysclk` in 1: the single clock for the whole block.
- `reset_n` in 1: reset, synchronous and active-low.
- `rx` in 1: asynchronous serial input; idles high.
- `data_out` out 8: received byte at the FIFO head.
- `data_valid` out 1: FIFO is non-empty.
- `data_ready` in 1: consumer accepts `data_out` this cycle.
- `framing_err` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: one-cycle pulse when a byte is dropped because the FIFO is full.
- `busy` out 1: high while the receiver is outside IDLE.

## Operation
- Bit period constant: `CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE`, integer-truncated (173 at the defaults).
- Mid-bit point: `HALF_BIT = CLKS_PER_BIT / 2` (86 at the defaults).
- Input path: `rx` passes through a 2-flop synchroniser, giving `rx_s`.
- Bit counter: a 16-bit down-counter reloaded on every state entry. It also reloads on every bit in DATA and on the parity bit when parity is compiled in.
- FSM states and transitions:
  - **IDLE**: on `rx_s` == 0, load `HALF_BIT` and go to START.
  - **START**: when the counter expires, re-sample. If `rx_s` == 1 this is a false start; return to IDLE with no pulse. Otherwise load `CLKS_PER_BIT`, clear the bit index, and go to DATA.
  - **DATA**: on each expiry, shift `rx_s` into the shift register, LSB first. After bit index 7, go to STOP, or to PARITY when it is compiled in.
  - **STOP**: on expiry, if `rx_s` == 1, push the byte and go to IDLE. If `rx_s` == 0, pulse `framing_err`, discard the byte, and go to BREAK.
  - **BREAK**: wait for `rx_s` == 1, then go to IDLE. A held-low line therefore never produces spurious bytes.
- FIFO behaviour:
  - A pop happens when `data_valid && data_ready`.
  - A push while full drops the new byte and pulses `overrun`. Stored contents are unchanged.
  - Push and pop in the same cycle while full: both happen and no overrun is reported.
  - Push and pop in the same cycle while empty: there is no fall-through. The pushed byte becomes visible next cycle.
- `data_out` always shows the FIFO head. Its value is don't-care while `data_valid` is 0.
- Reset mid-frame abandons the frame, flushes the FIFO and forces IDLE. No error pulse is produced.

## Timing
- Reset values: `data_out` = 0x00; `data_valid`, `framing_err`, `overrun` and `busy` all 0; state IDLE; FIFO pointers 0.
- Start detection: `rx_s` lags `rx` by 2 cycles. START is entered 1 cycle after `rx_s` falls.
- Latency from the `rx_s` falling edge (START entry) to the push: HALF_BIT + 9·CLKS_PER_BIT cycles, plus CLKS_PER_BIT more with parity. `data_valid` rises on the cycle after the push.
- `framing_err` and `overrun` each assert for exactly one cycle, registered.
- `busy` rises on START entry and falls on IDLE entry.

## Configuration
- Macro: `XC_UART_RX_PARITY_EN`.
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - On mismatch, the byte is discarded and `framing_err` pulses at the stop sample.
  - The stop-bit check still applies.
- Undefined: the frame is 8N1, the PARITY state is absent, and there is no parity logic.

## Structure
- Package `xc_uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the `xc_byte_t` type, 8 bits;
  - the function computing `CLKS_PER_BIT` from the two parameters.
- Sub-module `xc_byte_fifo`: a synchronous FIFO, parameterised by depth, with `reset_n` flush and full/empty flags. The FSM lives in the top module.

## Test plan
- Single byte: send 0xA5 at 57600 baud on a 10 MHz clock with `data_ready` = 1.
  - `data_out` = 0xA5 with `data_valid` high for 1 cycle.
  - No error pulses; `busy` returns low.
- Glitch rejection: drive `rx` low for 40 cycles, then high.
  - No byte, no `framing_err`; `busy` pulses and returns to IDLE.
- Framing error: send 0x3C with the stop bit forced low, then release the line.
  - One `framing_err` pulse; FIFO stays empty; the next valid byte 0x11 is received correctly.
- Overrun: with `data_ready` = 0, send 0x01 through 0x05.
  - One `overrun` pulse on the fifth byte.
  - Raising `data_ready` drains 0x01, 0x02, 0x03, 0x04 in order.
- Reset mid-frame: assert `reset_n` low for 1 cycle during data bit 4 of 0xFF.
  - All outputs at their reset values; no byte delivered.
  - A following 0x5A is received intact.
- Parity build (`XC_UART_RX_PARITY_EN` defined):
  - 0x07 with parity bit 1 is accepted.
  - 0x07 with parity bit 0 gives `framing_err` and no byte.
